// File: rtl/aes_pkg.sv
// Shared AES constants and types: S-box, round constants, round count and the
// key-expansion FSM state type.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Forward S-box, shared with the encryption SubBytes stage.
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/sub_word.sv
// SubWord: forward S-box applied independently to each byte of a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign word_out[8*i +: 8] = sbox(word_in[8*i +: 8]);
    end

endmodule

// File: rtl/dec_key_expansion.sv
// Iterative AES-128 key expansion: one round key per clock into an 11-entry
// bank, with a flat bank view and a registered random-access read port.
module dec_key_expansion
    import aes_pkg::*;
#(
    parameter int BLOCK_LENGTH = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BLOCK_LENGTH-1:0]   key_in,
    output logic                      busy,
    output logic                      done,
    output logic                      keys_valid,
    output logic [11*BLOCK_LENGTH-1:0] round_keys,
    input  logic [3:0]                rd_idx,
    output logic [BLOCK_LENGTH-1:0]   rd_key,
    output state_t                    fsm_state
);

    // Handshake: start is a one-sided request taken only in IDLE (busy low);
    // there is no backpressure, and a start seen while busy is dropped.

    logic [BLOCK_LENGTH-1:0] rk [0:10];
    logic [3:0]              rnd;
    logic [3:0]              prev_idx;
    logic [BLOCK_LENGTH-1:0] prev_key;
    logic [BLOCK_LENGTH-1:0] next_key;
    logic [7:0]              rcon_b;
    logic [31:0]             rot_w;
    logic [31:0]             sub_w;
    logic [31:0]             t_w;
    logic [31:0]             w0;
    logic [31:0]             w1;
    logic [31:0]             w2;
    logic [31:0]             w3;

    always_comb begin
        prev_idx = rnd - 4'd1;
        prev_key = (prev_idx <= NR) ? rk[prev_idx] : '0;
        rcon_b   = (rnd >= 4'd1 && rnd <= NR) ? RCON[rnd] : 8'h00;
        rot_w    = {prev_key[23:0], prev_key[31:24]};
    end

    sub_word u_sub_word (
        .word_in  (rot_w),
        .word_out (sub_w)
    );

    always_comb begin
        t_w      = sub_w ^ {rcon_b, 24'h0};
        w0       = prev_key[127:96] ^ t_w;
        w1       = prev_key[95:64]  ^ w0;
        w2       = prev_key[63:32]  ^ w1;
        w3       = prev_key[31:0]   ^ w2;
        next_key = {w0, w1, w2, w3};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_state  <= IDLE;
            rnd        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            for (int k = 0; k < 11; k++) begin
                rk[k] <= '0;
            end
        end else begin
            case (fsm_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rk[0]      <= key_in;
                        rnd        <= 4'd1;
                        keys_valid <= 1'b0;
                        busy       <= 1'b1;
                        fsm_state  <= EXPAND;
                    end
                end
                EXPAND: begin
                    rk[rnd] <= next_key;
                    if (rnd == NR) begin
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                        fsm_state  <= IDLE;
                    end else begin
                        rnd <= rnd + 4'd1;
                    end
                end
                default: fsm_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_key <= '0;
        end else begin
            rd_key <= (rd_idx <= NR) ? rk[rd_idx] : '0;
        end
    end

    for (genvar k = 0; k < 11; k++) begin : g_flat
        assign round_keys[k*BLOCK_LENGTH +: BLOCK_LENGTH] = rk[k];
    end

endmodule

// File: doc/dec_key_expansion.md
# dec_key_expansion

Iterative AES-128 key-expansion engine for the pipelined decryption datapath. It sits upstream of the decryption round stages. From one cipher key it computes round keys 0..10, producing one round key per clock, and holds all eleven in a register bank. The decryption pipeline consumes the bank in reverse order: key 10 for the initial round, keys 9..1 for the middle rounds, key 0 for the final AddRoundKey. A registered random-access read port serves debug and iterative use.

## Interface
- BLOCK_LENGTH, 128, width of the key and of each round key; only 128 is supported.
- clk  input  1  clock, all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request expansion of key_in; accepted only in IDLE.
- key_in  input  128  cipher key, sampled on the accepted start edge. Word w0 = bits [127:96].
- busy  output  1  high while in EXPAND.
- done  output  1  one-cycle pulse when round key 10 has been written.
- keys_valid  output  1  high from done until the next accepted start or reset.
- round_keys  output  11*128  flat bank; round key k occupies bits [128k+127 : 128k].
- rd_idx  input  4  read-port round index, 0..10.
- rd_key  output  128  registered round key selected by rd_idx.

## Operation
- FSM states: IDLE, EXPAND.
- **IDLE + start:**
  - rk[0] <= key_in.
  - rnd <= 1.
  - keys_valid <= 0.
  - Go to EXPAND.
- **IDLE without start:** hold all state.
- **EXPAND, each cycle:**
  - t = SubWord(RotWord(w3 of rk[rnd-1])) ^ {RCON[rnd], 24'h0}.
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - rk[rnd] <= {w0', w1', w2', w3'}; rnd <= rnd + 1.
- **EXPAND, rnd == 10:** after writing rk[10], go to IDLE, pulse done, set keys_valid.
- **start while in EXPAND:** ignored. No restart, no queueing.
- **start in the cycle done is high:** accepted, because the FSM is already in IDLE. keys_valid falls on that edge.
- **Bank writes:** rk[k] entries not yet rewritten during an expansion keep their old values. Consumers must qualify with keys_valid.
- **Read port:**
  - rd_key <= rk[rd_idx] every cycle, independent of FSM state.
  - rd_idx 11..15 yields 128'h0.
- **RotWord:** rotate the 32-bit word left by one byte.
- **SubWord:** forward AES S-box applied to each of the 4 bytes.
- **Round counter:** rnd is 4 bits and never exceeds 10.

## Timing
- Reset (rst low, asynchronous) clears:
  - FSM to IDLE; rnd to 0.
  - busy, done, keys_valid to 0.
  - All rk[0..10] and rd_key to 128'h0.
- Reset mid-expansion aborts immediately; keys_valid stays 0 after release.
- Latency, with start sampled at edge E:
  - rk[0] is written at E; busy is high from E.
  - rk[k] is written at edge E+k.
  - done is high for the cycle after edge E+10; busy falls at the same edge.
  - Total: 11 edges from start to keys_valid.
- round_keys is a direct register view with zero added latency.
- rd_key has 1-cycle latency from rd_idx.
- Critical path: one S-box lookup plus four 32-bit XOR levels.

## Structure
- Shared package aes_pkg holds:
  - RCON constant array [1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Round-count constant NR = 10.
  - FSM state typedef.
- Sub-module sub_word: purely combinational, 32-bit in / 32-bit out, four forward S-box instances. It uses the same S-box table as the encryption SubBytes.
- The register bank and read mux stay in the top module.

## Test plan
- **FIPS-197 vector:** key_in = 2b7e151628aed2a6abf7158809cf4f3c, pulse start.
  - rk[1] = a0fafe1788542cb123a339392a6c7605.
  - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done pulses exactly 11 cycles after the start edge.
- **Second vector and read port:** key_in = 000102030405060708090a0b0c0d0e0f.
  - rk[10] = 13111d7fe3944a17f307a78b4d2b30c5.
  - rd_idx = 10 gives that value on rd_key one cycle later.
  - rd_idx = 12 gives 128'h0.
- **start ignored while busy:** assert start with a different key during EXPAND.
  - Results equal those of the original key.
  - done pulses once.
- **Back-to-back:** assert start in the done cycle with the second key.
  - keys_valid drops on that edge.
  - The second expansion completes 11 cycles later with the correct keys.
- **Reset mid-expansion:** assert rst low at rnd = 5.
  - All outputs are 0 immediately and the FSM is in IDLE.
  - A following start produces correct keys.
- **keys_valid hold:** after done, idle for 50 cycles.
  - keys_valid stays 1 and round_keys stays unchanged.
